// File: rtl/cluster_output_checker.sv
// cluster_output_checker
// ----------------------
// Sits behind the per-bit learned output modules of a CPU cluster. Each accepted
// cycle captures the assembled predicted next-state vector and the golden vector
// from the reference model. The pair is compared through a two-stage pipeline:
//   S1: diff = pred ^ gold, plus the 0-based test number
//   S2: any-mismatch flag and lowest mismatching bit index
// One cycle after S2 the statistics update. Accept-to-counter latency is 3 cycles.
// The statistics are saturating test and error counters plus the location of the
// first failing vector. The accuracy figures for a run are read from these outputs.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          pulse; clears the stats and begins a run (honoured in IDLE/DONE)
//   num_tests      number of vectors to accept this run, sampled on start
//   in_valid       pred/gold are valid this cycle
//   in_ready       checker accepts a vector this cycle (decoded from state only)
//   pred, gold     predicted and golden vectors
//   busy, done     run in progress (RUN or DRAIN) / run complete (level)
//   test_cnt       vectors compared
//   err_cnt        vectors with at least one mismatching bit
//   first_err_v    a failing vector has been latched this run
//   first_err_idx  lowest mismatching bit of the first failing vector
//   first_err_tst  test number of the first failing vector
//
// Optional feature: define CHK_ERR_MASK_EN to add the err_mask output. It is the
// sticky OR of every diff vector seen this run.
module cluster_output_checker #(
  parameter int OUT_W = 1894,
  parameter int CNT_W = 32,
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] pred,
  input  logic [OUT_W-1:0] gold,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] test_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_v,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [CNT_W-1:0] first_err_tst
`ifdef CHK_ERR_MASK_EN
  ,
  output logic [OUT_W-1:0] err_mask
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_tests_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_next;

  logic             s1_v;
  logic [OUT_W-1:0] s1_diff;
  logic [CNT_W-1:0] s1_tst;

  logic             s2_v;
  logic             s2_any;
  logic [IDX_W-1:0] s2_idx;
  logic [CNT_W-1:0] s2_tst;

  logic             enc_any;
  logic [IDX_W-1:0] enc_idx;
  logic             accept;
  logic             start_ok;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign acc_next = acc_cnt + CNT_W'(1);

  // Lowest set bit of the S1 diff. The loop runs downward so the lowest index
  // is the last one written and therefore wins.
  always_comb begin
    enc_any = |s1_diff;
    enc_idx = '0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      if (s1_diff[i]) enc_idx = IDX_W'(i);
    end
  end

  // Run control. The run leaves RUN on the accept that reaches num_tests.
  // DRAIN then waits until both pipeline stages are empty. By that point the
  // last vector has already reached the statistics, so done means they are final.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      num_tests_q <= '0;
      acc_cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_tests_q <= num_tests;
            acc_cnt     <= '0;
            state       <= (num_tests == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_next;
            if (acc_next == num_tests_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_v && !s2_v) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Compare pipeline. An accepted start flushes both valids, so no vector left
  // over from an earlier run can reach the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_diff <= '0;
      s1_tst  <= '0;
      s2_v    <= 1'b0;
      s2_any  <= 1'b0;
      s2_idx  <= '0;
      s2_tst  <= '0;
    end else begin
      s1_v <= accept && !start_ok;
      s2_v <= s1_v && !start_ok;
      if (accept) begin
        s1_diff <= pred ^ gold;
        s1_tst  <= acc_cnt;
      end
      if (s1_v) begin
        s2_any <= enc_any;
        s2_idx <= enc_idx;
        s2_tst <= s1_tst;
      end
    end
  end

  // Statistics. The counters saturate at all-ones. Only the first failing
  // vector of a run is recorded; later failures never overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_cnt      <= '0;
      err_cnt       <= '0;
      first_err_v   <= 1'b0;
      first_err_idx <= '0;
      first_err_tst <= '0;
`ifdef CHK_ERR_MASK_EN
      err_mask      <= '0;
`endif
    end else if (start_ok) begin
      test_cnt      <= '0;
      err_cnt       <= '0;
      first_err_v   <= 1'b0;
      first_err_idx <= '0;
      first_err_tst <= '0;
`ifdef CHK_ERR_MASK_EN
      err_mask      <= '0;
`endif
    end else if (s2_v) begin
      if (test_cnt != '1) test_cnt <= test_cnt + CNT_W'(1);
      if (s2_any && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if (s2_any && !first_err_v) begin
        first_err_v   <= 1'b1;
        first_err_idx <= s2_idx;
        first_err_tst <= s2_tst;
      end
    end
`ifdef CHK_ERR_MASK_EN
    if (rst_n && !start_ok && s1_v) err_mask <= err_mask | s1_diff;
`endif
  end

endmodule
